gen_step_ctrl: RTL

GEN_STEP_CTRL -- requirements
Module: gen_step_ctrl

---
 rtl/gen_step_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/gen_step_ctrl.sv
// Game-of-Life generation stepper: scans the visible grid one cell per cycle into a scratch grid,
// then commits the whole scratch grid to the visible grid in a single cycle.
module gen_step_ctrl #(
  parameter int unsigned GRID_W = 16,
  parameter int unsigned GRID_H = 16,
  localparam int unsigned X_W = $clog2(GRID_W),
  localparam int unsigned Y_W = $clog2(GRID_H)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic           i_wr_en,
  input  logic [X_W-1:0] i_wr_x,
  input  logic [Y_W-1:0] i_wr_y,
  input  logic           i_wr_data,
  input  logic [X_W-1:0] i_rd_x,
  input  logic [Y_W-1:0] i_rd_y,
  output logic           o_rd_data,
  output logic           o_busy,
  output logic           o_done,
  output logic [15:0]    o_gen_cnt
);

  localparam int unsigned NEIGHBOURS_CNT = 8;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StCalc   = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;

  localparam logic [X_W-1:0] XLast = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] YLast = Y_W'(GRID_H - 1);

  // Conway rule: survive on 2 or 3 live neighbours, birth on exactly 3.
  function automatic logic next_cell_state(input logic                      self,
                                           input logic [NEIGHBOURS_CNT-1:0] nbrs);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < NEIGHBOURS_CNT; i++) begin
      cnt = cnt + {3'b000, nbrs[i]};
    end
    return (cnt == 4'd3) || (self && (cnt == 4'd2));
  endfunction

  logic [1:0]                   state_q, state_d;
  logic [X_W-1:0]               x_q, x_d;
  logic [Y_W-1:0]               y_q, y_d;
  logic [GRID_H-1:0][GRID_W-1:0] cur_q, cur_d;
  logic [GRID_H-1:0][GRID_W-1:0] nxt_q, nxt_d;
  logic                         done_q, done_d;
  logic [15:0]                  gen_cnt_q, gen_cnt_d;

  logic [X_W-1:0]            xm, xp;
  logic [Y_W-1:0]            ym, yp;
  logic [NEIGHBOURS_CNT-1:0] nbrs;
  logic                      new_cell;
  logic                      wr_ok, rd_ok;

  // Toroidal neighbour coordinates; explicit compares keep non-power-of-two sizes correct.
  always_comb begin
    xm = (x_q == '0)    ? XLast : x_q - 1'b1;
    xp = (x_q == XLast) ? '0    : x_q + 1'b1;
    ym = (y_q == '0)    ? YLast : y_q - 1'b1;
    yp = (y_q == YLast) ? '0    : y_q + 1'b1;
    nbrs = {cur_q[yp][xp], cur_q[yp][x_q], cur_q[yp][xm],
            cur_q[y_q][xp], cur_q[y_q][xm],
            cur_q[ym][xp], cur_q[ym][x_q], cur_q[ym][xm]};
    new_cell = next_cell_state(cur_q[y_q][x_q], nbrs);
  end

  assign wr_ok = (32'(i_wr_x) < GRID_W) && (32'(i_wr_y) < GRID_H);
  assign rd_ok = (32'(i_rd_x) < GRID_W) && (32'(i_rd_y) < GRID_H);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    done_d    = 1'b0;
    gen_cnt_d = gen_cnt_q;
    case (state_q)
      StIdle: begin
        // The write lands in the same edge that launches CALC, so the scan sees it.
        if (i_wr_en && wr_ok) begin
          cur_d[i_wr_y][i_wr_x] = i_wr_data;
        end
        if (i_start) begin
          state_d = StCalc;
          x_d     = '0;
          y_d     = '0;
        end
      end
      StCalc: begin
        nxt_d[y_q][x_q] = new_cell;
        if (x_q == XLast) begin
          x_d = '0;
          if (y_q == YLast) begin
            y_d     = '0;
            state_d = StCommit;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      StCommit: begin
        cur_d     = nxt_q;
        done_d    = 1'b1;
        gen_cnt_d = gen_cnt_q + 16'd1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      cur_q     <= '0;
      nxt_q     <= '0;
      done_q    <= 1'b0;
      gen_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      done_q    <= done_d;
      gen_cnt_q <= gen_cnt_d;
    end
  end

  assign o_rd_data = rd_ok ? cur_q[i_rd_y][i_rd_x] : 1'b0;
  assign o_busy    = (state_q != StIdle);
  assign o_done    = done_q;
  assign o_gen_cnt = gen_cnt_q;

endmodule
